// File: rtl/imem_line_responder.sv
// Single-line instruction buffer: combinational hit path, req/ack line refill on miss.
// Define IMEM_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module imem_line_responder #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned WORD_W     = 33
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] pc,
   input  logic              flush,
   output logic [WORD_W-1:0] instruction,
   output logic              hold,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata
`ifdef IMEM_PERF_CNT_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int unsigned IDX_W = $clog2(LINE_WORDS);
   localparam int unsigned TAG_W = WORD_W - 2 - IDX_W;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic              line_valid;
   logic [TAG_W-1:0]  line_tag;
   logic [WORD_W-1:0] data [LINE_WORDS];
   logic [IDX_W-1:0]  cnt;
   logic [TAG_W-1:0]  fill_tag;
   logic              kill;

   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic              hit;
   logic              start_fill;
   logic              beat_wr;
   logic              fill_done;
   logic              unused_pc_lo;

   assign pc_idx       = pc[2 +: IDX_W];
   assign pc_tag       = pc[WORD_W-1 -: TAG_W];
   assign unused_pc_lo = ^pc[1:0];

   assign hit         = (state == IDLE) && line_valid && (line_tag == pc_tag) && !flush;
   assign hold        = !hit;
   assign instruction = hit ? data[pc_idx] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      start_fill = 1'b0;
      beat_wr    = 1'b0;
      fill_done  = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (state)
         IDLE: begin
            if (!hit) begin
               state_nx   = FILL;
               start_fill = 1'b1;
            end
         end
         FILL: begin
            mem_req = 1'b1;
            // fill base has zero low bits, so concatenation equals base + 4*cnt modulo 2^WORD_W
            mem_addr = {fill_tag, cnt, 2'b00};
            if (mem_ack) begin
               beat_wr = 1'b1;
               if (cnt == LAST_BEAT) begin
                  fill_done = 1'b1;
                  state_nx  = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         line_valid <= 1'b0;
         line_tag   <= '0;
         cnt        <= '0;
         fill_tag   <= '0;
         kill       <= 1'b0;
         for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            data[i] <= '0;
         end
      end else begin
         if (start_fill) begin
            fill_tag <= pc_tag;
            cnt      <= '0;
            kill     <= 1'b0;
            if (flush) begin
               line_valid <= 1'b0;
            end
         end
         // a flush mid-refill lets the bus finish but poisons the resulting line
         if ((state == FILL) && flush) begin
            kill <= 1'b1;
         end
         if (beat_wr) begin
            data[cnt] <= mem_rdata;
            cnt       <= cnt + IDX_W'(1);
         end
         if (fill_done) begin
            line_tag   <= fill_tag;
            line_valid <= !kill && !flush;
         end
      end
   end

`ifdef IMEM_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit && (hit_count != '1)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (start_fill && (miss_count != '1)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: a backing memory returning addr+0x100
// with a configurable per-beat wait, checked against hand-computed values.
module tb_imem_line_responder;

   logic        clk;
   logic        reset;
   logic [32:0] pc;
   logic        flush;
   logic [32:0] instruction;
   logic        hold;
   logic        mem_req;
   logic [32:0] mem_addr;
   logic        mem_ack;
   logic [32:0] mem_rdata;
`ifdef IMEM_PERF_CNT_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   int          wait_n   = 0;
   logic        force_ack;
   logic [1:0]  wcnt;
   int          hc;

   imem_line_responder #(
      .LINE_WORDS(4),
      .WORD_W    (33)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .flush      (flush),
      .instruction(instruction),
      .hold       (hold),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
`ifdef IMEM_PERF_CNT_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory: acks after wait_n idle cycles per beat; force_ack injects stray acks.
   assign mem_ack   = (mem_req && (int'(wcnt) == wait_n)) || force_ack;
   assign mem_rdata = mem_addr + 33'h100;

   always @(posedge clk or negedge reset) begin
      if (!reset) wcnt <= '0;
      else if (mem_req && !mem_ack) wcnt <= wcnt + 2'd1;
      else wcnt <= '0;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   // Beats of a refill already in progress, ending settled in the first IDLE cycle after.
   task automatic fill_beats(input logic [32:0] base, input int waits, inout int hcount);
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w <= waits; w++) begin
            next_cycle();
            flush = 1'b0;
            settle();
            if (hold) hcount++;
            check("beat_req", 64'(mem_req), 64'd1);
            check("beat_addr", 64'(mem_addr), 64'(base + 33'(4 * b)));
            check("beat_hold", 64'(hold), 64'd1);
         end
      end
      next_cycle();
      settle();
   endtask

   // Called in the cycle a missing pc is presented.
   task automatic run_fill(input logic [32:0] base, input int waits, output int hcount);
      settle();
      hcount = 0;
      if (hold) hcount++;
      check("miss_hold", 64'(hold), 64'd1);
      check("miss_req", 64'(mem_req), 64'd0);
      fill_beats(base, waits, hcount);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b0;
      pc        = '0;
      flush     = 1'b0;
      force_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      settle();
      check("rst_hold", 64'(hold), 64'd1);
      check("rst_req", 64'(mem_req), 64'd0);
      check("rst_addr", 64'(mem_addr), 64'd0);
      check("rst_instr", 64'(instruction), 64'd0);

      // Cold miss at pc=0, zero-wait memory
      next_cycle();
      reset = 1'b1;
      pc    = 33'd0;
      run_fill(33'd0, 0, hc);
      check("cold_hold_cycles", 64'(hc), 64'd5);
      check("cold_hit_hold", 64'(hold), 64'd0);
      check("cold_hit_instr", 64'(instruction), 64'h100);

      for (int i = 0; i < 4; i++) begin
         next_cycle();
         pc = 33'(4 * i);
         settle();
         check("step_hold", 64'(hold), 64'd0);
         check("step_instr", 64'(instruction), 64'(33'h100 + 33'(4 * i)));
         check("step_req", 64'(mem_req), 64'd0);
      end

      // Next line replaces line 0; returning to pc=0 misses again
      next_cycle();
      pc = 33'd16;
      run_fill(33'd16, 0, hc);
      check("l1_hold", 64'(hold), 64'd0);
      check("l1_instr", 64'(instruction), 64'h110);
      next_cycle();
      pc = 33'd0;
      run_fill(33'd0, 0, hc);
      check("l0_again_instr", 64'(instruction), 64'h100);

      // Two wait cycles per beat
      next_cycle();
      pc     = 33'd32;
      wait_n = 2;
      run_fill(33'd32, 2, hc);
      check("wait_hold_cycles", 64'(hc), 64'd13);
      check("wait_instr0", 64'(instruction), 64'h120);
      next_cycle();
      wait_n = 0;
      pc     = 33'd44;
      settle();
      check("wait_instr3", 64'(instruction), 64'h12C);

      // Stray ack with no request outstanding
      next_cycle();
      force_ack = 1'b1;
      settle();
      check("stray_ack_hold", 64'(hold), 64'd0);
      check("stray_ack_req", 64'(mem_req), 64'd0);
      next_cycle();
      force_ack = 1'b0;
      settle();
      check("stray_ack_after", 64'(instruction), 64'h12C);
      check("stray_ack_after_req", 64'(mem_req), 64'd0);

      // Flush while idle: miss this cycle, refill yields a valid line
      next_cycle();
      flush = 1'b1;
      settle();
      check("idle_flush_hold", 64'(hold), 64'd1);
      check("idle_flush_instr", 64'(instruction), 64'd0);
      hc = 0;
      fill_beats(33'd32, 0, hc);
      check("idle_flush_refill", 64'(instruction), 64'h12C);
      check("idle_flush_refill_hold", 64'(hold), 64'd0);

      // Flush on the 2nd beat; pc wanders mid-fill
      next_cycle();
      pc = 33'd64;
      settle();
      check("fl_miss", 64'(hold), 64'd1);
      next_cycle();
      settle();
      check("fl_beat0", 64'(mem_addr), 64'd64);
      next_cycle();
      flush = 1'b1;
      settle();
      check("fl_beat1", 64'(mem_addr), 64'd68);
      check("fl_beat1_hold", 64'(hold), 64'd1);
      next_cycle();
      flush = 1'b0;
      pc    = 33'd200;
      settle();
      check("fl_beat2", 64'(mem_addr), 64'd72);
      next_cycle();
      pc = 33'd64;
      settle();
      check("fl_beat3", 64'(mem_addr), 64'd76);
      next_cycle();
      settle();
      check("fl_remiss_hold", 64'(hold), 64'd1);
      check("fl_remiss_req", 64'(mem_req), 64'd0);
      hc = 0;
      fill_beats(33'd64, 0, hc);
      check("fl_refill_hold", 64'(hold), 64'd0);
      check("fl_refill_instr", 64'(instruction), 64'h140);

      // Reset during the 3rd beat
      next_cycle();
      pc = 33'd128;
      settle();
      check("rs_miss", 64'(hold), 64'd1);
      next_cycle();
      settle();
      check("rs_beat0", 64'(mem_addr), 64'd128);
      next_cycle();
      settle();
      check("rs_beat1", 64'(mem_addr), 64'd132);
      next_cycle();
      reset = 1'b0;
      settle();
      check("rs_req", 64'(mem_req), 64'd0);
      check("rs_hold", 64'(hold), 64'd1);
      check("rs_addr", 64'(mem_addr), 64'd0);
      next_cycle();
      reset = 1'b1;
      run_fill(33'd128, 0, hc);
      check("rs_refill_instr", 64'(instruction), 64'h180);

      // Top of address space: no carry into tag, data wraps modulo 2^33
      next_cycle();
      pc = 33'h1_FFFF_FFF0;
      run_fill(33'h1_FFFF_FFF0, 0, hc);
      check("wrap_instr0", 64'(instruction), 64'h0_0000_00F0);
      next_cycle();
      pc = 33'h1_FFFF_FFFC;
      settle();
      check("wrap_hold", 64'(hold), 64'd0);
      check("wrap_instr3", 64'(instruction), 64'h0_0000_00FC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_line_responder.md
Name: imem_line_responder

Overview:
- Instruction-memory responder on the far end of the fetch interface.
- Receives the fetch PC and returns the instruction word combinationally in the same cycle on a hit.
- Asserts hold toward fetch on a miss and refills a single line buffer from backing memory over a req/ack bus.
- Sits between the fetch stage and the instruction ROM/RAM controller.

Parameters:
- LINE_WORDS, 4, 33-bit words per line buffer; power of two, ≥2.
- WORD_W, 33, instruction/PC width, matching the fetch datapath.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- pc  input  WORD_W  fetch byte address, word aligned (pc[1:0]==0).
- flush  input  1  invalidate the line buffer.
- instruction  output  WORD_W  instruction at pc; combinational.
- hold  output  1  fetch must stall; combinational.
- mem_req  output  1  backing-memory read request.
- mem_addr  output  WORD_W  byte address of the requested word.
- mem_ack  input  1  beat accepted; mem_rdata valid this cycle.
- mem_rdata  input  WORD_W  returned word.

Behaviour:
- Address split (IDX_W = log2(LINE_WORDS)):
  - word index = pc[2 +: IDX_W]
  - tag = pc[WORD_W-1 : 2+IDX_W]
  - line base = {tag, IDX_W+2 zero bits}
- State: line_valid, line_tag, line data[LINE_WORDS], FSM state, beat counter cnt, fill base fbase, sticky flag kill.
- Reset (async, reset==0) clears everything:
  - line_valid=0, state=IDLE, cnt=0, kill=0.
  - Outputs: hold=1 (miss), instruction=0, mem_req=0, mem_addr=0.
- hit = (state==IDLE) && line_valid && (line_tag==pc tag) && !flush.
- Outputs:
  - hold = !hit.
  - instruction = data[word index] when hit, else 0.
- FSM IDLE:
  - On hit: no state change.
  - On miss: at the posedge, fbase <= line base of pc, cnt <= 0, kill <= 0, go to FILL. If flush was high in that cycle, line_valid <= 0.
- FSM FILL:
  - mem_req=1, mem_addr = fbase + 4*cnt. Both are held stable until mem_ack.
  - On mem_ack: data[cnt] <= mem_rdata, cnt <= cnt+1.
  - On mem_ack with cnt==LINE_WORDS-1: line_tag <= fbase tag, line_valid <= !kill && !flush, go to IDLE.
  - mem_ack while mem_req==0 is ignored.
- Latency:
  - Hit: 0 cycles (instruction is valid in the same cycle pc is presented).
  - Miss with zero-wait memory (mem_ack high in every FILL cycle): hold is high for LINE_WORDS+1 cycles, then the hit.
  - Each memory wait cycle adds 1 cycle.
- flush:
  - In IDLE: line_valid <= 0; hold=1 that cycle.
  - In FILL: the refill completes, since the bus is not aborted mid-beat. kill <= 1, the finished line stays invalid, and the FSM returns to IDLE and re-misses.
- pc changing during FILL: ignored. The refill uses the latched fbase. After return to IDLE the new pc is compared normally and may miss again.
- Data buffer is updated in place during a refill. Because line_valid is not reused until the refill completes, partial lines are never returned.
- Wrap-around: a line base at the top of the address space fills without carrying into the tag. mem_addr is computed modulo 2^WORD_W.
- Async reset mid-FILL: mem_req drops immediately, the line is invalid, the state is IDLE, and any outstanding ack is ignored.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- Defined:
  - Adds output ports hit_count [31:0] and miss_count [31:0], both reset to 0.
  - hit_count increments on every IDLE cycle with hit=1.
  - miss_count increments once per IDLE→FILL transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset release, pc=0, zero-wait memory returning rdata=addr+33'h100:
  - Cycle 0: hold=1.
  - Cycles 1-4: mem_req=1 with mem_addr=0,4,8,12.
  - Cycle 5: hold=0, instruction=33'h100.
- After fill, pc stepped 0,4,8,12 one per cycle → hold=0 throughout; instruction=33'h100,33'h104,33'h108,33'h10C; mem_req stays 0.
- pc=16 after line 0 is resident → miss, refill at mem_addr 16,20,24,28; then instruction=33'h110; pc=0 misses again (single line).
- Refill with mem_ack delayed 2 cycles per beat → mem_addr stable across wait cycles; hold high for 1+4*3=13 cycles; final data correct.
- flush pulsed on the 2nd FILL beat → all 4 beats complete, then IDLE; the same pc misses and refills again.
- reset driven low during the 3rd FILL beat → mem_req=0 immediately, hold=1. After release, a fresh refill starts from beat 0 at the line base.
